// File: rtl/gpio_axis_pkg.sv
// -----------------------------------------------------------------------------
// gpio_axis_pkg
// Shared helpers for the multi-channel GPIO -> AXI-Stream bridge:
//   clog2()         ceiling log2 usable in constant expressions
//   ch_width()      tdest / channel-index width, never less than 1
//   addr_width()    FIFO pointer width, never less than 1
//   ch_idx_t        channel index wide enough for the 16-channel maximum
//   GPIO_AXIS_SLICE packed-bus slice of channel i from a flat wdata bus
// -----------------------------------------------------------------------------
`ifndef GPIO_AXIS_PKG_SV
`define GPIO_AXIS_PKG_SV

`define GPIO_AXIS_SLICE(bus, i, w) bus[(i)*(w) +: (w)]

package gpio_axis_pkg;

    localparam int MAX_CH = 16;

    typedef logic [3:0] ch_idx_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

    function automatic int addr_width(input int depth);
        return (depth <= 1) ? 1 : clog2(depth);
    endfunction

endpackage

`endif

// File: rtl/gpio_axis_chan_fifo.sv
// -----------------------------------------------------------------------------
// gpio_axis_chan_fifo
// One source channel: write-strobe edge detect, DEPTH-entry sync FIFO with
// drop-new overflow handling and a sticky overflow flag.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clr          synchronous flush; wen history keeps tracking wen
//   wen, wdata   source write strobe and payload
//   pop          consume head entry (only asserted when !empty)
//   rd_data      head entry, combinational from storage
//   empty        no entries stored
//   overflow     sticky: a push arrived while full
// -----------------------------------------------------------------------------
module gpio_axis_chan_fifo
    import gpio_axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int WEN_EDGE   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  overflow
);

    localparam int AW = addr_width(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr, rptr;
    logic [CW-1:0]         count;
    logic                  wen_q;
    logic                  push, full, wr_en;

    assign push    = (WEN_EDGE != 0) ? (wen & ~wen_q) : wen;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Full is judged before any same-cycle pop: a push on full is dropped.
    assign wr_en   = push & ~full;
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst_n && !clr && wr_en)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wen_q    <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            // Keep tracking wen so a strobe held across the flush cannot re-fire.
            wen_q    <= wen;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wen_q <= wen;
            if (wr_en)
                wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            if (push && full)
                overflow <= 1'b1;
            if (pop)
                rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gpio_to_axis_mux_fifo.sv
// -----------------------------------------------------------------------------
// gpio_to_axis_mux_fifo
// NUM_CH GPIO write sources, each buffered in its own FIFO, merged round-robin
// onto one AXI-Stream master. tdest carries the source channel.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   clr              synchronous soft flush
//   wen[NUM_CH]      per-channel write strobe
//   wdata            flat bus, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   overflow         sticky per-channel drop flags
//   m_axis_*         AXI-Stream master (tdata, tdest, tlast, tvalid, tready)
// Build option: define GPIO_AXIS_TLAST_EN for BURST_LEN-beat packets per
// channel with the arbiter locked to a channel for the whole packet; without
// it every beat carries tlast and arbitration is per beat.
// -----------------------------------------------------------------------------
module gpio_to_axis_mux_fifo
    import gpio_axis_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int WEN_EDGE   = 1,
    parameter int BURST_LEN  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic [NUM_CH-1:0]            wen,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wdata,
    output logic [NUM_CH-1:0]            overflow,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [ch_width(NUM_CH)-1:0]  m_axis_tdest,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready
);

    localparam int CH_W = ch_width(NUM_CH);

    logic [NUM_CH-1:0]                 empty;
    logic [NUM_CH-1:0]                 pop;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] dout;

    logic [CH_W-1:0] rr_ptr;   // first channel the next search looks at
    logic [CH_W-1:0] gnt, cand;
    logic            gnt_vld, load, beat_last;
    int              idx;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        gpio_axis_chan_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .WEN_EDGE   (WEN_EDGE)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .wen      (wen[i]),
            .wdata    (`GPIO_AXIS_SLICE(wdata, i, DATA_WIDTH)),
            .pop      (pop[i]),
            .rd_data  (dout[i]),
            .empty    (empty[i]),
            .overflow (overflow[i])
        );
    end

`ifdef GPIO_AXIS_TLAST_EN
    localparam int BW = (BURST_LEN <= 1) ? 1 : clog2(BURST_LEN);

    logic [NUM_CH-1:0][BW-1:0] beat_cnt;
    logic                      locked;
    logic [CH_W-1:0]           lock_ch;

    assign beat_last = (beat_cnt[gnt] == BW'(BURST_LEN - 1));

    // Lock is taken when a non-final beat is loaded and dropped with the
    // final one; the single output slot means the next load can only happen
    // once that final beat has fired.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            beat_cnt <= '0;
            locked   <= 1'b0;
            lock_ch  <= '0;
        end else if (load) begin
            beat_cnt[gnt] <= beat_last ? '0 : beat_cnt[gnt] + 1'b1;
            locked        <= ~beat_last;
            lock_ch       <= gnt;
        end
    end
`else
    // Every beat closes a packet.
    assign beat_last = (BURST_LEN >= 1);
`endif

    // Round-robin search from rr_ptr; descending loop so the lowest offset wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        cand    = '0;
        idx     = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            cand = CH_W'(idx);
            if (!empty[cand]) begin
                gnt_vld = 1'b1;
                gnt     = cand;
            end
        end
`ifdef GPIO_AXIS_TLAST_EN
        // Mid-packet: only the locked channel may feed the output.
        if (locked) begin
            gnt_vld = ~empty[lock_ch];
            gnt     = lock_ch;
        end
`endif
    end

    assign load = gnt_vld & (~m_axis_tvalid | m_axis_tready);

    always_comb begin
        pop = '0;
        if (load) pop[gnt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tdest  <= '0;
            m_axis_tlast  <= 1'b0;
            rr_ptr        <= '0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= dout[gnt];
            m_axis_tdest  <= gnt;
            m_axis_tlast  <= beat_last;
            rr_ptr        <= (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gpio_to_axis_mux_fifo.sv
// -----------------------------------------------------------------------------
// tb_gpio_to_axis_mux_fifo
// Self-checking bench: a negedge monitor pops an expected-beat queue on every
// handshake and checks output stability during stalls; the main sequence
// fills the queue as it drives stimulus.
// -----------------------------------------------------------------------------
module tb_gpio_to_axis_mux_fifo;

    localparam int NUM_CH = 4;
    localparam int DW     = 32;
    localparam int DEPTH  = 4;
    localparam int BURST  = 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     clr = 1'b0;
    logic [NUM_CH-1:0]        wen = '0;
    logic [NUM_CH*DW-1:0]     wdata = '0;
    logic [NUM_CH-1:0]        overflow;
    logic [DW-1:0]            tdata;
    logic [1:0]               tdest;
    logic                     tlast, tvalid;
    logic                     tready = 1'b0;

    always #5 clk = ~clk;

    gpio_to_axis_mux_fifo #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .WEN_EDGE   (1),
        .BURST_LEN  (BURST)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (clr),
        .wen           (wen),
        .wdata         (wdata),
        .overflow      (overflow),
        .m_axis_tdata  (tdata),
        .m_axis_tdest  (tdest),
        .m_axis_tlast  (tlast),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    dest;
        logic          last;
    } beat_t;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
        logic [1:0]    exp_dest;
        logic [DW-1:0] exp_data;
    } vec_t;

    beat_t exp_q[$];
    vec_t  tbl[8];
    int    tb_cnt[NUM_CH];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected tlast of the next beat from channel ch.
    function automatic logic next_last(input int ch);
        logic l;
`ifdef GPIO_AXIS_TLAST_EN
        l = (tb_cnt[ch] == BURST - 1);
        tb_cnt[ch] = l ? 0 : tb_cnt[ch] + 1;
`else
        l = 1'b1;
`endif
        return l;
    endfunction

    task automatic expect_beat(input int ch, input logic [DW-1:0] data);
        beat_t b;
        b.data = data;
        b.dest = 2'(ch);
        b.last = next_last(ch);
        exp_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        foreach (tb_cnt[i]) tb_cnt[i] = 0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        clr    = 1'b0;
        wen    = '0;
        tready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_model();
    endtask

    // One push on every channel in mask; channel c gets base + 16*c.
    task automatic push(input logic [NUM_CH-1:0] mask, input logic [DW-1:0] base);
        for (int c = 0; c < NUM_CH; c++) wdata[c*DW +: DW] = base + DW'(c * 16);
        wen = mask;
        tick();
        wen = '0;
        tick();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Two words per channel, loaded with tready low; slot grabs ch0 word0 first.
    task automatic fill_all(input logic [DW-1:0] base);
        push(4'hF, base);
        push(4'hF, base + 1);
        tick();
`ifdef GPIO_AXIS_TLAST_EN
        for (int c = 0; c < NUM_CH; c++)
            for (int w = 0; w < 2; w++) expect_beat(c, base + DW'(c * 16 + w));
`else
        for (int w = 0; w < 2; w++)
            for (int c = 0; c < NUM_CH; c++) expect_beat(c, base + DW'(c * 16 + w));
`endif
    endtask

    // Leave words queued with tvalid up and overflow[2] set.
    task automatic load_stale();
        for (int k = 0; k < 4; k++) push(4'b0010, 32'h600 + DW'(k));
        for (int k = 0; k < 5; k++) push(4'b0100, 32'h700 + DW'(k));
        chk("t6_pre_tvalid", 64'(tvalid), 64'd1);
        chk("t6_pre_overflow", 64'(overflow), 64'b0100);
    endtask

    // Monitor: scoreboard pop on handshake, hold check during stalls.
    initial begin
        beat_t cur, prev, e;
        logic  stall;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            cur = {tdata, tdest, tlast};
            if (!rst_n || clr) begin
                stall = 1'b0;
            end else begin
                if (stall) chk("stall_hold", {28'd0, tvalid, cur}, {28'd0, 1'b1, prev});
                if (tvalid && tready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL extra_beat: got data %0h dest %0d, expected no beat", tdata, tdest);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 64'(cur), 64'(e));
                    end
                end
                stall = tvalid && !tready;
                prev  = cur;
            end
        end
    end

    initial begin
        tbl[0] = '{2, 32'hA5A5_0002, 2'd2, 32'hA5A5_0002};
        tbl[1] = '{2, 32'h0000_0000, 2'd2, 32'h0000_0000};
        tbl[2] = '{0, 32'hFFFF_FFFF, 2'd0, 32'hFFFF_FFFF};
        tbl[3] = '{0, 32'h1234_5678, 2'd0, 32'h1234_5678};
        tbl[4] = '{3, 32'h8000_0001, 2'd3, 32'h8000_0001};
        tbl[5] = '{3, 32'h5A5A_5A5A, 2'd3, 32'h5A5A_5A5A};
        tbl[6] = '{1, 32'hDEAD_BEEF, 2'd1, 32'hDEAD_BEEF};
        tbl[7] = '{1, 32'h0F0F_0F0F, 2'd1, 32'h0F0F_0F0F};

        do_reset();
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tdata", 64'(tdata), 64'd0);
        chk("rst_tdest", 64'(tdest), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        // Isolated pushes: 2-cycle latency, one beat despite a held strobe.
        tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            wdata = '0;
            wdata[tbl[i].ch*DW +: DW] = tbl[i].data;
            wen = '0;
            wen[tbl[i].ch] = 1'b1;
            expect_beat(int'(tbl[i].exp_dest), tbl[i].exp_data);
            @(negedge clk); chk("t1_lat_pre", 64'(tvalid), 64'd0);
            @(negedge clk); chk("t1_lat_fifo", 64'(tvalid), 64'd0);
            @(negedge clk); chk("t1_lat_valid", 64'(tvalid), 64'd1);
            @(negedge clk); chk("t1_single", 64'(tvalid), 64'd0);
            @(negedge clk); chk("t1_no_repeat", 64'(tvalid), 64'd0);
            @(negedge clk); chk("t1_no_repeat", 64'(tvalid), 64'd0);
            tick();
            wen = '0;
        end
        wait_drain("t1_drain", 10);

        // Overflow: slot plus DEPTH entries accepted, sixth push dropped.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            push(4'b0010, 32'h10 + DW'(k) - 32'h10);
            if (k < 5) expect_beat(1, 32'h10 + DW'(k) + 32'h10 - 32'h10);
            if (k == 4) chk("t2_no_ovf_yet", 64'(overflow), 64'd0);
        end
        chk("t2_overflow", 64'(overflow), 64'b0010);
        tready = 1'b1;
        wait_drain("t2_drain", 20);
        chk("t2_ovf_sticky", 64'(overflow), 64'b0010);

        // Round-robin order, back-to-back.
        do_reset();
        fill_all(32'h300);
        tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t3_no_bubble", 64'(tvalid), 64'd1);
        end
        wait_drain("t3_drain", 10);

        // Random backpressure: monitor checks hold and order.
        do_reset();
        fill_all(32'h400);
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
            tready = 1'($urandom_range(0, 1));
            tick();
        end
        tready = 1'b1;
        wait_drain("t4_drain", 20);

        // Two channels, four words each.
        do_reset();
        for (int w = 0; w < 4; w++) push(4'b1001, 32'h500 + DW'(w) - DW'(0));
        chk("t5_no_overflow", 64'(overflow), 64'd0);
`ifdef GPIO_AXIS_TLAST_EN
        for (int p = 0; p < 2; p++) begin
            for (int w = 0; w < 2; w++) expect_beat(0, 32'h500 + DW'(2 * p + w));
            for (int w = 0; w < 2; w++) expect_beat(3, 32'h530 + DW'(2 * p + w));
        end
`else
        for (int w = 0; w < 4; w++) begin
            expect_beat(0, 32'h500 + DW'(w));
            expect_beat(3, 32'h530 + DW'(w));
        end
`endif
        tready = 1'b1;
        wait_drain("t5_drain", 20);

        // Soft flush with a strobe rising during the flush and held after it.
        do_reset();
        load_stale();
        wdata[0 +: DW] = 32'hDEAD;
        wen = 4'b0001;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        clear_model();
        @(negedge clk);
        chk("t6_clr_tvalid", 64'(tvalid), 64'd0);
        chk("t6_clr_overflow", 64'(overflow), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_no_refire", 64'(tvalid), 64'd0);
        end
        tick();
        wen = '0;
        tick();
        wdata[0 +: DW] = 32'h77;
        wen = 4'b0001;
        expect_beat(0, 32'h77);
        tick();
        wen = '0;
        tready = 1'b1;
        wait_drain("t6_clr_drain", 10);

        // Same via hard reset mid-operation.
        tready = 1'b0;
        load_stale();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_model();
        chk("t6_rst_tvalid", 64'(tvalid), 64'd0);
        chk("t6_rst_overflow", 64'(overflow), 64'd0);
        chk("t6_rst_tdata", 64'(tdata), 64'd0);
        wdata[0 +: DW] = 32'h77;
        wen = 4'b0001;
        expect_beat(0, 32'h77);
        tick();
        wen = '0;
        tready = 1'b1;
        wait_drain("t6_rst_drain", 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
